// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the halt opcode, the NOP encoding
// and the fetch-state encoding used by the instruction-fetch stage.
package cpu_pkg;

   localparam int PC_W = 5;
   localparam int INSTR_W = 32;
   localparam logic [5:0] HALT_OP = 6'h3F;
   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's pipeline-facing signals: hazard/redirect
// controls, the instruction-memory port and the IF/ID register outputs.
interface if_stage_if #(
   parameter int PC_W = cpu_pkg::PC_W,
   parameter int INSTR_W = cpu_pkg::INSTR_W
);
   logic stall;
   logic redirect_valid;
   logic [PC_W-1:0] redirect_pc;
   logic [PC_W-1:0] imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic ifid_valid;
   logic [INSTR_W-1:0] ifid_instr;
   logic [PC_W-1:0] ifid_pc;
   logic [PC_W-1:0] ifid_pc_plus1;
   logic halted;

   // The fetch stage itself
   modport master (
      input stall, redirect_valid, redirect_pc, imem_rdata,
      output imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus1, halted
   );

   // Everything around it: hazard unit, branch resolution, memory, decode
   modport slave (
      output stall, redirect_valid, redirect_pc, imem_rdata,
      input imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus1, halted
   );
endinterface

// File: rtl/if_stage_pc_incr.sv
// PC incrementer: adds one and wraps silently at 2^W (no carry-out).
module pc_incr #(
   parameter int W = cpu_pkg::PC_W
) (
   input  logic [W-1:0] pc,
   output logic [W-1:0] pc_plus1
);

   assign pc_plus1 = pc + W'(1);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory,
// captures the fetched word into the IF/ID register and stops fetching
// when it sees the halt opcode until a redirect or reset restarts it.
module if_stage #(
   parameter int PC_W = cpu_pkg::PC_W,
   parameter int INSTR_W = cpu_pkg::INSTR_W,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [5:0] HALT_OP = cpu_pkg::HALT_OP
) (
   input logic clk,
   input logic rst,
   if_stage_if.master bus
);
   import cpu_pkg::*;

   fetch_state_t state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] ifid_pc_q;
   logic [PC_W-1:0] ifid_pc_plus1_q;
   logic [INSTR_W-1:0] ifid_instr_q;
   logic ifid_valid_q;
   logic halt_fetched;

   // pc_next doubles as the captured ifid_pc_plus1, since ifid_pc is the current pc
   pc_incr #(.W(PC_W)) u_pc_incr (
      .pc(pc),
      .pc_plus1(pc_next)
   );

   assign halt_fetched = (bus.imem_rdata[INSTR_W-1 -: 6] == HALT_OP);

   // PC, IF/ID register and fetch FSM; redirect beats stall, stall freezes everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= INSTR_W'(NOP);
         ifid_pc_q <= '0;
         ifid_pc_plus1_q <= '0;
         state <= RUN;
      end else if (bus.redirect_valid) begin
         pc <= bus.redirect_pc;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= INSTR_W'(NOP);
         state <= RUN;
      end else if (!bus.stall) begin
         case (state)
            RUN: begin
               ifid_instr_q <= bus.imem_rdata;
               ifid_pc_q <= pc;
               ifid_pc_plus1_q <= pc_next;
               ifid_valid_q <= 1'b1;
               if (halt_fetched) begin
                  state <= HALTED;
               end else begin
                  pc <= pc_next;
               end
            end
            HALTED: begin
               ifid_valid_q <= 1'b0;
               ifid_instr_q <= INSTR_W'(NOP);
            end
            default: state <= RUN;
         endcase
      end
   end

   assign bus.imem_addr = pc;
   assign bus.ifid_valid = ifid_valid_q;
   assign bus.ifid_instr = ifid_instr_q;
   assign bus.ifid_pc = ifid_pc_q;
   assign bus.ifid_pc_plus1 = ifid_pc_plus1_q;
   assign bus.halted = (state == HALTED);

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU. Owns the program-counter register, drives the instruction-memory address, and chooses the next PC: PC+1, redirect target, or hold.
- Registers the fetched instruction into the IF/ID pipeline register for decode.
- Consumes the PC+1 value from its incrementer and sits directly upstream of decode.

Parameters:
- PC_W, 5, PC / instruction-memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- HALT_OP, 6'h3F, opcode in instr[31:26] that halts fetch

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  from hazard unit; freeze PC and IF/ID
- redirect_valid  in  1  branch/jump resolved taken; load redirect_pc and flush IF/ID
- redirect_pc  in  PC_W  redirect target
- imem_addr  out  PC_W  equals the PC register (combinational)
- imem_rdata  in  INSTR_W  instruction at imem_addr, combinational read, same cycle
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_instr  out  INSTR_W  registered instruction
- ifid_pc  out  PC_W  PC of ifid_instr
- ifid_pc_plus1  out  PC_W  ifid_pc+1 mod 2^PC_W
- halted  out  1  fetch FSM is in HALTED

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC
  - ifid_valid = 0, ifid_instr = 0 (NOP), ifid_pc = 0, ifid_pc_plus1 = 0
  - FSM = RUN, halted = 0
  - Deasserting rst starts fetch at RESET_PC on the first following posedge. Reset mid-operation discards all in-flight state.
- pc_next = pc+1 truncated to PC_W, so 31 wraps to 0 with no carry-out. Same rule for ifid_pc_plus1.
- FSM has two states: RUN and HALTED. halted = (state == HALTED).
- Per-posedge priority, highest first:
  1. redirect_valid=1 (any state, stall ignored):
     - pc <= redirect_pc
     - ifid_valid <= 0, ifid_instr <= 0
     - state <= RUN
  2. stall=1:
     - pc, IF/ID and state all hold.
  3. state=RUN, no stall:
     - ifid_instr <= imem_rdata, ifid_pc <= pc, ifid_pc_plus1 <= pc_next, ifid_valid <= 1.
     - If imem_rdata[31:26]==HALT_OP: state <= HALTED and pc holds. The halt instruction itself is delivered valid.
     - Otherwise pc <= pc_next.
  4. state=HALTED, no stall:
     - pc holds, ifid_valid <= 0, ifid_instr <= 0.
     - Leaves HALTED only via redirect or reset.
- Latency: an instruction at address A appears on ifid_* one cycle after pc==A with no stall. Back-to-back throughput is one instruction per cycle.
- Simultaneous events:
  - redirect + stall: redirect wins.
  - redirect + halt opcode fetched: the halt is squashed and FSM stays RUN.
  - stall while a halt opcode is on imem_rdata: no capture and no transition until the stall drops.
- No combinational path from stall or redirect to imem_addr; imem_addr changes only on a clock edge or reset.

Decomposition:
- Shared package/header cpu_pkg:
  - PC_W, INSTR_W, HALT_OP, NOP encoding (0)
  - fetch-state encoding: RUN=1'b0, HALTED=1'b1
- One sub-module, pc_incr: combinational PC_W-bit +1 with wrap. Used for both pc_next and ifid_pc_plus1. All sequential logic stays in if_stage.

Test Plan:
1. Reset, then imem returns 32'h0000_0001 everywhere; run 3 cycles -> imem_addr 0,1,2; ifid_pc 0,1 with ifid_pc_plus1 1,2; ifid_valid=1 from the first edge.
2. pc=31, no stall -> next imem_addr=0; ifid_pc=31, ifid_pc_plus1=0.
3. At pc=4 hold stall=1 for 2 cycles -> imem_addr stays 4 and ifid_* unchanged for both edges; fetch resumes at 5 after release.
4. At pc=6 with stall=1, assert redirect_valid with redirect_pc=20 -> next edge: imem_addr=20, ifid_valid=0, ifid_instr=0; following edge captures address 20.
5. imem_rdata=32'hFC00_0000 at pc=9 -> ifid_instr=FC00_0000, valid=1, halted=1, pc stays 9; next edge ifid_valid=0. Redirect to 2 -> halted=0 and fetch restarts at 2.
6. Assert rst asynchronously mid-cycle while halted with pc=9 -> pc, ifid_*, halted all reset immediately, without waiting for a clock edge.
